// File: rtl/usb_hid_key_event_decoder.sv
// rtl/usb_hid_key_event_decoder.sv - HID boot-keyboard report diff to press/release event FIFO
//
// usb_hid_key_event_fifo: show-ahead event queue.
//   push/push_data in, pop_ready in (pops when head valid), head/valid out,
//   overflow out (sticky, set when a push is lost on a full queue).
//
// usb_hid_key_event_decoder: assembles KEYS+2 byte reports, diffs them against the
// last committed report and queues one event per changed keycode.
//   clk, rst (async, active-low)
//   usb_data/usb_valid/usb_start in, usb_ready out : byte-serial report input
//   key_data/key_release/key_mod/key_valid out, key_ready in : event FIFO head
//   report_err out : one-cycle pulse on aborted or rollover report
//   overflow out   : sticky event-drop flag

module usb_hid_key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          full;
  logic          do_push;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = valid && pop_ready;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !pop)      count <= count + CNT_ONE;
      else if (pop && !do_push) count <= count - CNT_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module usb_hid_key_event_decoder #(
  parameter int KEYS       = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] usb_data,
  input  logic       usb_valid,
  input  logic       usb_start,
  output logic       usb_ready,
  output logic [7:0] key_data,
  output logic       key_release,
  output logic [7:0] key_mod,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       report_err,
  output logic       overflow
);
  localparam int CW = $clog2(KEYS + 2);
  localparam int IW = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(KEYS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(KEYS - 1);

  typedef enum logic [1:0] {COLLECT, SCAN_PRESS, SCAN_REL, COMMIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [7:0]    new_key  [KEYS];
  logic [7:0]    prev_key [KEYS];
  logic [7:0]    new_mod;
  logic          accept;
  logic          is_abort;
  logic          is_last;
  logic          is_rollover;
  logic          press_hit;
  logic          rel_hit;
  logic          push;
  logic          push_rel;
  logic [7:0]    push_key;
  logic [16:0]   fifo_head;

  assign accept   = usb_valid && (state == COLLECT);
  assign is_abort = accept && usb_start && (cnt != '0);
  assign is_last  = accept && !usb_start && (cnt == LAST_CNT);

  // Rollover: the incoming last keycode plus every keycode already stored are 0x01.
  always_comb begin
    is_rollover = (usb_data == 8'h01);
    for (int k = 0; k < KEYS - 1; k++) begin
      if (new_key[k] != 8'h01) is_rollover = 1'b0;
    end
  end

  // Slot idx produces an event only if its key is absent from the other report
  // and is the first occurrence within its own report.
  always_comb begin
    press_hit = (new_key[idx] != 8'h00);
    rel_hit   = (prev_key[idx] != 8'h00);
    for (int j = 0; j < KEYS; j++) begin
      if (prev_key[j] == new_key[idx]) press_hit = 1'b0;
      if (new_key[j] == prev_key[idx]) rel_hit = 1'b0;
      if (IW'(j) < idx) begin
        if (new_key[j] == new_key[idx])   press_hit = 1'b0;
        if (prev_key[j] == prev_key[idx]) rel_hit = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    usb_ready = 1'b0;
    push      = 1'b0;
    push_rel  = 1'b0;
    push_key  = 8'h00;
    case (state)
      COLLECT: begin
        usb_ready = 1'b1;
        if (is_last && !is_rollover) state_nxt = SCAN_PRESS;
      end
      SCAN_PRESS: begin
        push     = press_hit;
        push_key = new_key[idx];
        if (idx == LAST_IDX) state_nxt = SCAN_REL;
      end
      SCAN_REL: begin
        push     = rel_hit;
        push_rel = 1'b1;
        push_key = prev_key[idx];
        if (idx == LAST_IDX) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      new_mod    <= 8'h00;
      report_err <= 1'b0;
      for (int k = 0; k < KEYS; k++) begin
        new_key[k]  <= 8'h00;
        prev_key[k] <= 8'h00;
      end
    end else begin
      report_err <= is_abort || (is_last && is_rollover);
      if (accept) begin
        if (usb_start) begin
          new_mod <= usb_data;
          cnt     <= CW'(1);
        end else if (cnt != '0) begin
          // Byte 1 (reserved) matches no slot and is dropped.
          for (int k = 0; k < KEYS; k++) begin
            if (cnt == CW'(k + 2)) new_key[k] <= usb_data;
          end
          cnt <= is_last ? '0 : cnt + CW'(1);
        end
      end
      if (state == SCAN_PRESS || state == SCAN_REL) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
      if (state == COMMIT) begin
        for (int k = 0; k < KEYS; k++) prev_key[k] <= new_key[k];
      end
    end
  end

  usb_hid_key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (17)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_rel, push_key, new_mod}),
    .pop_ready (key_ready),
    .head      (fifo_head),
    .valid     (key_valid),
    .overflow  (overflow)
  );

  assign {key_release, key_data, key_mod} = fifo_head;
endmodule

// File: tb/tb_usb_hid_key_event_decoder.sv
// tb/tb_usb_hid_key_event_decoder.sv - self-checking bench for usb_hid_key_event_decoder
`timescale 1ns/1ps
module tb_usb_hid_key_event_decoder;
  localparam int KEYS  = 6;
  localparam int DEPTH = 2;
  localparam int RLEN  = KEYS + 2;
  localparam int SCAN  = 2 * KEYS;

  typedef struct packed { logic rel; logic [7:0] key; logic [7:0] mod; } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] usb_data = 8'h00;
  logic       usb_valid = 1'b0;
  logic       usb_start = 1'b0;
  logic       usb_ready;
  logic [7:0] key_data;
  logic       key_release;
  logic [7:0] key_mod;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic       report_err;
  logic       overflow;

  int  compared = 0;
  int  mismatched = 0;
  bit  rand_ready = 1'b0;
  bit  mon_on = 1'b0;
  ev_t got[$];

  // Reference model state
  logic [7:0] m_prev [KEYS];
  logic [7:0] m_new  [KEYS];
  logic [7:0] m_mod;
  int         m_cnt;
  int         m_busy;
  bit         m_err;
  bit         m_ovf;
  ev_t        m_q[$];
  ev_t        sched   [SCAN];
  bit         sched_v [SCAN];
  logic [20:0] mon_act, mon_exp;

  usb_hid_key_event_decoder #(.KEYS(KEYS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .usb_data(usb_data), .usb_valid(usb_valid),
    .usb_start(usb_start), .usb_ready(usb_ready), .key_data(key_data),
    .key_release(key_release), .key_mod(key_mod), .key_valid(key_valid),
    .key_ready(key_ready), .report_err(report_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int k = 0; k < KEYS; k++) begin m_prev[k] = 8'h00; m_new[k] = 8'h00; end
    m_mod = 8'h00; m_cnt = 0; m_busy = 0; m_err = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // Diff the new report against the committed one: presses in new-slot order,
  // then releases in prev-slot order, each tagged with the new modifier.
  task automatic m_plan();
    ev_t seen_p[$];
    logic [7:0] seen_k[$];
    for (int s = 0; s < SCAN; s++) sched_v[s] = 0;
    for (int i = 0; i < KEYS; i++) begin
      bit in_prev = 0;
      bit dup = 0;
      foreach (m_prev[j]) if (m_prev[j] == m_new[i]) in_prev = 1;
      foreach (seen_k[j]) if (seen_k[j] == m_new[i]) dup = 1;
      seen_k.push_back(m_new[i]);
      if (m_new[i] != 8'h00 && !in_prev && !dup) begin
        sched_v[i] = 1; sched[i] = {1'b0, m_new[i], m_mod};
      end
    end
    seen_k.delete();
    for (int i = 0; i < KEYS; i++) begin
      bit in_new = 0;
      bit dup = 0;
      foreach (m_new[j]) if (m_new[j] == m_prev[i]) in_new = 1;
      foreach (seen_k[j]) if (seen_k[j] == m_prev[i]) dup = 1;
      seen_k.push_back(m_prev[i]);
      if (m_prev[i] != 8'h00 && !in_new && !dup) begin
        sched_v[KEYS+i] = 1; sched[KEYS+i] = {1'b1, m_prev[i], m_mod};
      end
    end
    seen_p.delete();
    m_prev = m_new;
    m_busy = SCAN + 1;
  endtask

  task automatic m_step();
    bit  pop, push, roll;
    int  size0, step;
    ev_t pe;
    size0 = m_q.size();
    pop = (size0 > 0) && key_ready;
    push = 0; pe = '0; m_err = 0;
    if (m_busy > 0) begin
      step = SCAN + 1 - m_busy;
      if (step < SCAN && sched_v[step]) begin push = 1; pe = sched[step]; end
      m_busy--;
    end else if (usb_valid) begin
      if (usb_start) begin
        if (m_cnt != 0) m_err = 1;
        m_mod = usb_data; m_cnt = 1;
      end else if (m_cnt != 0) begin
        if (m_cnt >= 2) m_new[m_cnt-2] = usb_data;
        if (m_cnt == KEYS + 1) begin
          m_cnt = 0;
          roll = 1;
          foreach (m_new[k]) if (m_new[k] != 8'h01) roll = 0;
          if (roll) m_err = 1;
          else m_plan();
        end else m_cnt++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (size0 < DEPTH || pop) m_q.push_back(pe);
      else m_ovf = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (mon_on && rst) begin
      mon_act = {usb_ready, report_err, overflow, key_valid,
                 key_valid ? {key_release, key_data, key_mod} : 17'h0};
      mon_exp = {m_busy == 0, m_err, m_ovf, m_q.size() > 0,
                 (m_q.size() > 0) ? m_q[0] : 17'h0};
      compared++;
      if (mon_act !== mon_exp) begin
        mismatched++;
        $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready) key_ready = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input bit s);
    int guard = 0;
    if (rand_ready) repeat ($urandom_range(0, 2)) tick();
    usb_valid = 1'b1; usb_data = d; usb_start = s;
    while (!usb_ready && guard < 200) begin tick(); guard++; end
    if (guard >= 200) begin
      compared++; mismatched++;
      $display("FAIL send_timeout actual=usb_ready_low required=accept_within_200");
    end
    tick();
    usb_valid = 1'b0; usb_start = 1'b0;
  endtask

  task automatic send_report(input logic [8*RLEN-1:0] r);
    for (int b = 0; b < RLEN; b++) send_byte(r[8*(RLEN-1-b) +: 8], b == 0);
  endtask

  task automatic collect(input int n);
    got.delete();
    repeat (n) begin
      if (key_valid && key_ready) got.push_back({key_release, key_data, key_mod});
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    compared++;
    if ({usb_ready, key_valid, overflow, report_err} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_state actual=%b required=1000", {usb_ready, key_valid, overflow, report_err});
    end
    rst = 1'b1;
    mon_on = 1'b1;
    tick();
  endtask

  task automatic test_press();
    send_report({8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    compared++;
    if ({usb_ready, key_valid} !== 2'b00) begin
      mismatched++; $display("FAIL press_t1 actual=%b required=00", {usb_ready, key_valid});
    end
    tick();
    compared++;
    if ({key_valid, key_release, key_data, key_mod} !== {1'b1, 1'b0, 8'h04, 8'h00}) begin
      mismatched++;
      $display("FAIL press_t2 actual=%h required=%h", {key_valid, key_release, key_data, key_mod},
               {1'b1, 1'b0, 8'h04, 8'h00});
    end
    repeat (11) tick();
    compared++;
    if (usb_ready !== 1'b0) begin mismatched++; $display("FAIL press_ready_t13 actual=%b required=0", usb_ready); end
    tick();
    compared++;
    if ({usb_ready, key_valid} !== 2'b10) begin
      mismatched++; $display("FAIL press_t14 actual=%b required=10", {usb_ready, key_valid});
    end
  endtask

  task automatic test_multi_key();
    send_report({8'h00, 8'h00, 8'h04, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 1 || got[0] !== {1'b0, 8'h16, 8'h00}) begin
      mismatched++; $display("FAIL multi_setup actual_count=%0d required=1 (press 16)", got.size());
    end
    send_report({8'h02, 8'h00, 8'h16, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 2 || got[0] !== {1'b0, 8'h07, 8'h02} || got[1] !== {1'b1, 8'h04, 8'h02}) begin
      mismatched++;
      $display("FAIL multi_diff actual_count=%0d first=%h required=2 events 00702 then 10402",
               got.size(), (got.size() > 0) ? got[0] : 17'h0);
    end
  endtask

  task automatic test_dup_rollover();
    send_report({8'h00, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 3 || got[0] !== {1'b0, 8'h05, 8'h00} ||
        got[1] !== {1'b1, 8'h16, 8'h00} || got[2] !== {1'b1, 8'h07, 8'h00}) begin
      mismatched++; $display("FAIL dup_press actual_count=%0d required=3 (P05 R16 R07)", got.size());
    end
    send_report({8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01});
    compared++;
    if (report_err !== 1'b1) begin mismatched++; $display("FAIL rollover_err_t1 actual=%b required=1", report_err); end
    tick();
    compared++;
    if (report_err !== 1'b0) begin mismatched++; $display("FAIL rollover_err_width actual=%b required=0", report_err); end
    collect(SCAN + 4);
    compared++;
    if (got.size() != 0) begin mismatched++; $display("FAIL rollover_events actual=%0d required=0", got.size()); end
    send_report({8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 0) begin mismatched++; $display("FAIL rollover_prev_kept actual=%0d required=0", got.size()); end
    send_report({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 1 || got[0] !== {1'b1, 8'h05, 8'h00}) begin
      mismatched++; $display("FAIL release_05 actual_count=%0d required=1", got.size());
    end
  endtask

  task automatic test_abort();
    send_byte(8'h00, 1); send_byte(8'h00, 0); send_byte(8'h09, 0);
    send_byte(8'h03, 1);
    compared++;
    if (report_err !== 1'b1) begin mismatched++; $display("FAIL abort_err actual=%b required=1", report_err); end
    send_byte(8'h00, 0); send_byte(8'h0A, 0);
    repeat (KEYS - 1) send_byte(8'h00, 0);
    collect(SCAN + 4);
    compared++;
    if (got.size() != 1 || got[0] !== {1'b0, 8'h0A, 8'h03}) begin
      mismatched++; $display("FAIL abort_restart actual_count=%0d required=1 (P0A mod 03)", got.size());
    end
  endtask

  task automatic test_overflow();
    send_report({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL overflow_pre actual=%b required=0", overflow); end
    key_ready = 1'b0;
    send_report({8'h00, 8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00});
    repeat (SCAN + 2) tick();
    compared++;
    if ({key_valid, key_data, overflow} !== {1'b1, 8'h04, 1'b1}) begin
      mismatched++;
      $display("FAIL overflow_full actual=%h required=%h", {key_valid, key_data, overflow}, {1'b1, 8'h04, 1'b1});
    end
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    compared++;
    if ({key_valid, key_data} !== {1'b1, 8'h05}) begin
      mismatched++; $display("FAIL overflow_pop actual=%h required=105", {key_valid, key_data});
    end
    send_report({8'h00, 8'h00, 8'h07, 8'h08, 8'h09, 8'h00, 8'h00, 8'h00});
    tick(); key_ready = 1'b1; tick();
    compared++;
    if ({key_valid, key_data} !== {1'b1, 8'h07}) begin
      mismatched++; $display("FAIL push_pop_full actual=%h required=107", {key_valid, key_data});
    end
    collect(SCAN + 4);
    compared++;
    if (got.size() != 6 || got[0] !== {1'b0, 8'h07, 8'h00} || got[1] !== {1'b0, 8'h08, 8'h00} ||
        got[2] !== {1'b0, 8'h09, 8'h00} || got[3] !== {1'b1, 8'h04, 8'h00} ||
        got[4] !== {1'b1, 8'h05, 8'h00} || got[5] !== {1'b1, 8'h06, 8'h00}) begin
      mismatched++; $display("FAIL overflow_drain actual_count=%0d required=6 (P07 P08 P09 R04 R05 R06)", got.size());
    end
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL overflow_sticky actual=%b required=1", overflow); end
  endtask

  task automatic test_reset_midscan();
    send_report({8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({usb_ready, key_valid, overflow, report_err} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_midscan actual=%b required=1000", {usb_ready, key_valid, overflow, report_err});
    end
    @(negedge clk); rst = 1'b1; tick();
    send_report({8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    collect(SCAN + 4);
    compared++;
    if (got.size() != 1 || got[0] !== {1'b0, 8'h04, 8'h00}) begin
      mismatched++; $display("FAIL reset_reemit actual_count=%0d required=1 (P04)", got.size());
    end
  endtask

  task automatic test_random();
    logic [8*RLEN-1:0] r;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          send_byte(8'($urandom_range(0, 255)), 1);
          repeat ($urandom_range(1, KEYS)) send_byte(8'($urandom_range(0, 8)), 0);
        end
        1: send_byte(8'($urandom_range(0, 8)), 0);
        2: send_report({8'($urandom_range(0, 255)), 8'h00, {KEYS{8'h01}}});
        default: begin
          r[8*RLEN-1 -: 8] = 8'($urandom_range(0, 255));
          r[8*RLEN-9 -: 8] = 8'($urandom_range(0, 255));
          for (int k = 0; k < KEYS; k++) r[8*(KEYS-1-k) +: 8] = 8'($urandom_range(0, 8));
          send_report(r);
        end
      endcase
    end
    rand_ready = 1'b0;
    key_ready = 1'b1;
    repeat (SCAN + DEPTH + 6) tick();
    compared++;
    if (key_valid !== 1'b0 || usb_ready !== 1'b1) begin
      mismatched++; $display("FAIL random_drain actual=%b required=01", {key_valid, usb_ready});
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_multi_key();
    test_dup_rollover();
    test_abort();
    test_overflow();
    test_reset_midscan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
